// File: rtl/message_sequencer_pkg.sv
// Shared constants for the message sequencer: FSM state codes,
// message indices and the launch priority encoder.
package message_sequencer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int MSG_ACEITO       = 0;
    localparam int MSG_COMPROMETIDO = 1;
    localparam int MSG_REJEITADO    = 2;
    localparam int NUM_MSG          = 3;

    // rejeitado > comprometido > aceito; result is one-hot or zero
    function automatic logic [NUM_MSG-1:0] pick_msg(
        input logic [NUM_MSG-1:0] pend
    );
        logic [NUM_MSG-1:0] win;
        win = '0;
        if (pend[MSG_REJEITADO])
            win[MSG_REJEITADO] = 1'b1;
        else if (pend[MSG_COMPROMETIDO])
            win[MSG_COMPROMETIDO] = 1'b1;
        else if (pend[MSG_ACEITO])
            win[MSG_ACEITO] = 1'b1;
        return win;
    endfunction

endpackage

// File: rtl/message_sequencer_hold_timer.sv
// Hold timer: restarted by start_i, flags expired_o on the last
// of HOLD_CYCLES counted cycles, then goes idle.
module hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic expired_o
);

    logic              active_q, active_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    assign expired_o = active_q &&
        (cnt_q == HOLD_W'(HOLD_CYCLES - 1));

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (expired_o)
                active_d = 1'b0;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/message_sequencer.sv
// Message sequencer: queues status requests, selects one message at a
// time, streams its characters over valid/ready and holds it on screen.
module message_sequencer
    import message_sequencer_pkg::*;
#(
    parameter int CHAR_W      = 4,
    parameter int CNT_W       = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_aceito,
    input  logic              req_comprometido,
    input  logic              req_rejeitado,
    input  logic [CHAR_W-1:0] caracter,
    input  logic [CNT_W-1:0]  len_string,
    input  logic              display_ready,
    output logic              aceito,
    output logic              comprometido,
    output logic              rejeitado,
    output logic [CNT_W-1:0]  counter_caracter,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_valid,
    output logic              busy,
    output logic              done
);

    logic [2:0]         state_q, state_d;
    logic [NUM_MSG-1:0] pend_q, pend_d;
    logic [NUM_MSG-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CHAR_W-1:0]  char_q, char_d;
    logic               valid_q, valid_d;

    logic [NUM_MSG-1:0] req;
    logic [NUM_MSG-1:0] win;
    logic               hold_start;
    logic               hold_expired;

    always_comb begin
        req                   = '0;
        req[MSG_ACEITO]       = req_aceito;
        req[MSG_COMPROMETIDO] = req_comprometido;
        req[MSG_REJEITADO]    = req_rejeitado;
    end

    assign win = pick_msg(pend_q);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q | req;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        char_d     = char_q;
        valid_d    = valid_q;
        hold_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    // a request of the launched type this cycle is absorbed
                    pend_d  = (pend_q | req) & ~win;
                    sel_d   = win;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                len_d = len_string;
                if (len_string == '0) begin
                    sel_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                char_d  = caracter;
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (display_ready) begin
                    valid_d = 1'b0;
                    if (cnt_q == len_q - 1'b1) begin
                        hold_start = 1'b1;
                        state_d    = ST_HOLD;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_expired) begin
                    sel_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            char_q  <= char_d;
            valid_q <= valid_d;
        end
    end

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .HOLD_W      (HOLD_W)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .start_i   (hold_start),
        .expired_o (hold_expired)
    );

    assign aceito           = sel_q[MSG_ACEITO];
    assign comprometido     = sel_q[MSG_COMPROMETIDO];
    assign rejeitado        = sel_q[MSG_REJEITADO];
    assign counter_caracter = cnt_q;
    assign char_out         = char_q;
    assign char_valid       = valid_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_message_sequencer.sv
// Directed bench for message_sequencer with a behavioural stand-in
// for select_mensage (length and characters per selected message).
module tb_message_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_aceito = 1'b0;
    logic       req_comprometido = 1'b0;
    logic       req_rejeitado = 1'b0;
    logic [3:0] caracter;
    logic [3:0] len_string;
    logic       display_ready = 1'b1;
    logic       aceito, comprometido, rejeitado;
    logic [3:0] counter_caracter;
    logic [3:0] char_out;
    logic       char_valid, busy, done;

    logic [3:0] len_acc = 4'd7;
    logic [3:0] len_comp = 4'd4;
    logic [3:0] len_rej = 4'd2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int bad_sel = 0;
    bit valid_seen = 0;
    logic [2:0] x_sel[$];
    logic [3:0] x_idx[$];
    logic [3:0] x_ch[$];
    int x_cyc[$];

    message_sequencer #(
        .CHAR_W(4), .CNT_W(4), .HOLD_CYCLES(4), .HOLD_W(3)
    ) dut (
        .clk(clk), .reset(reset),
        .req_aceito(req_aceito),
        .req_comprometido(req_comprometido),
        .req_rejeitado(req_rejeitado),
        .caracter(caracter), .len_string(len_string),
        .display_ready(display_ready),
        .aceito(aceito), .comprometido(comprometido),
        .rejeitado(rejeitado),
        .counter_caracter(counter_caracter),
        .char_out(char_out), .char_valid(char_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // select_mensage stand-in: char = index + per-message offset
    always_comb begin
        len_string = 4'hF;
        caracter = counter_caracter;
        if (rejeitado) begin
            len_string = len_rej;
            caracter = counter_caracter + 4'd9;
        end else if (comprometido) begin
            len_string = len_comp;
            caracter = counter_caracter + 4'd5;
        end else if (aceito) begin
            len_string = len_acc;
            caracter = counter_caracter + 4'd1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (char_valid && display_ready) begin
                x_sel.push_back({rejeitado, comprometido, aceito});
                x_idx.push_back(counter_caracter);
                x_ch.push_back(char_out);
                x_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if ($countones({rejeitado, comprometido, aceito}) > 1)
                bad_sel = bad_sel + 1;
            if (char_valid) valid_seen = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        x_sel.delete();
        x_idx.delete();
        x_ch.delete();
        x_cyc.delete();
        done_cnt = 0;
        valid_seen = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({aceito, comprometido, rejeitado} !== 3'b000) begin
            errors++;
            $display("FAIL reset_sel got %b want 000",
                {aceito, comprometido, rejeitado});
        end
        checks++;
        if ({char_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000",
                {char_valid, busy, done});
        end
        checks++;
        if ({counter_caracter, char_out} !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h want 00",
                {counter_caracter, char_out});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        clear_log();
        len_acc = 4'd7;
        display_ready = 1'b1;
        req_aceito = 1'b1;
        tick();
        req_aceito = 1'b0;
        for (int i = 0; i < 300 && done_cnt < 1; i++) tick();
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL single_done got %0d want 1", done_cnt);
        end
        checks++;
        if (x_ch.size() !== 7) begin
            errors++;
            $display("FAIL single_count got %0d want 7", x_ch.size());
        end
        for (int i = 0; i < x_ch.size() && i < 7; i++) begin
            checks++;
            if (x_sel[i] !== 3'b001 || x_idx[i] !== 4'(i)
                || x_ch[i] !== 4'(i + 1)) begin
                errors++;
                $display("FAIL single_char%0d got %b/%0d/%h want 001/%0d/%h",
                    i, x_sel[i], x_idx[i], x_ch[i], i, 4'(i + 1));
            end
        end
        if (x_cyc.size() == 7) begin
            checks++;
            if (done_cyc - x_cyc[6] !== 5) begin
                errors++;
                $display("FAIL single_hold got %0d want 5",
                    done_cyc - x_cyc[6]);
            end
        end
        tick();
        checks++;
        if ({done, aceito, busy} !== 3'b000) begin
            errors++;
            $display("FAIL single_after got %b want 000",
                {done, aceito, busy});
        end
    endtask

    task automatic test_priority();
        clear_log();
        len_acc = 4'd3;
        len_rej = 4'd2;
        req_aceito = 1'b1;
        req_rejeitado = 1'b1;
        tick();
        req_aceito = 1'b0;
        req_rejeitado = 1'b0;
        for (int i = 0; i < 400 && done_cnt < 2; i++) tick();
        checks++;
        if (done_cnt !== 2) begin
            errors++;
            $display("FAIL prio_done got %0d want 2", done_cnt);
        end
        checks++;
        if (x_sel.size() !== 5) begin
            errors++;
            $display("FAIL prio_count got %0d want 5", x_sel.size());
        end else begin
            checks++;
            if (x_sel[0] !== 3'b100 || x_sel[1] !== 3'b100
                || x_ch[1] !== 4'd10) begin
                errors++;
                $display("FAIL prio_first got %b/%h want 100/a",
                    x_sel[1], x_ch[1]);
            end
            checks++;
            if (x_sel[2] !== 3'b001 || x_sel[4] !== 3'b001
                || x_ch[4] !== 4'd3) begin
                errors++;
                $display("FAIL prio_second got %b/%h want 001/3",
                    x_sel[4], x_ch[4]);
            end
        end
    endtask

    task automatic test_stall();
        clear_log();
        len_comp = 4'd4;
        display_ready = 1'b0;
        req_comprometido = 1'b1;
        tick();
        req_comprometido = 1'b0;
        for (int i = 0; i < 50 && !char_valid; i++) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({char_valid, char_out, counter_caracter} !== 9'h150) begin
                errors++;
                $display("FAIL stall%0d got v%b c%h n%0d want v1 c5 n0",
                    k, char_valid, char_out, counter_caracter);
            end
        end
        display_ready = 1'b1;
        for (int i = 0; i < 300 && done_cnt < 1; i++) tick();
        checks++;
        if (x_ch.size() !== 4 || done_cnt !== 1) begin
            errors++;
            $display("FAIL stall_count got %0d/%0d want 4/1",
                x_ch.size(), done_cnt);
        end else begin
            checks++;
            if (x_ch[0] !== 4'd5 || x_ch[3] !== 4'd8
                || x_sel[3] !== 3'b010) begin
                errors++;
                $display("FAIL stall_chars got %h %h %b want 5 8 010",
                    x_ch[0], x_ch[3], x_sel[3]);
            end
        end
    endtask

    task automatic test_empty();
        clear_log();
        len_acc = 4'd0;
        req_aceito = 1'b1;
        tick();
        req_aceito = 1'b0;
        for (int i = 0; i < 50 && done_cnt < 1; i++) tick();
        checks++;
        if (done_cnt !== 1 || valid_seen !== 1'b0) begin
            errors++;
            $display("FAIL empty got done%0d valid%b want done1 valid0",
                done_cnt, valid_seen);
        end
        tick();
        checks++;
        if ({aceito, comprometido, rejeitado, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL empty_after got %b want 0000",
                {aceito, comprometido, rejeitado, busy});
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        len_rej = 4'd6;
        display_ready = 1'b1;
        req_rejeitado = 1'b1;
        tick();
        req_rejeitado = 1'b0;
        for (int i = 0; i < 100 && x_ch.size() < 3; i++) tick();
        display_ready = 1'b0;
        req_aceito = 1'b1;
        tick();
        req_aceito = 1'b0;
        for (int i = 0; i < 20 && !char_valid; i++) tick();
        checks++;
        if (counter_caracter !== 4'd3 || char_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pos got n%0d v%b want n3 v1",
                counter_caracter, char_valid);
        end
        display_ready = 1'b1;
        reset = 1'b1;
        tick();
        checks++;
        if ({aceito, comprometido, rejeitado, char_valid, busy, done,
             counter_caracter, char_out} !== 14'h0) begin
            errors++;
            $display("FAIL mid_reset got %b/%h%h want 000000/00",
                {aceito, comprometido, rejeitado, char_valid, busy, done},
                counter_caracter, char_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (done_cnt !== 0 || x_ch.size() !== 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after got done%0d xfer%0d busy%b want 0 3 0",
                done_cnt, x_ch.size(), busy);
        end
    endtask

    task automatic test_repeat();
        clear_log();
        len_acc = 4'd3;
        len_comp = 4'd2;
        req_aceito = 1'b1;
        tick();
        req_aceito = 1'b0;
        for (int i = 0; i < 20 && !busy; i++) tick();
        for (int k = 0; k < 3; k++) begin
            req_comprometido = 1'b1;
            tick();
            req_comprometido = 1'b0;
            tick();
        end
        for (int i = 0; i < 400 && done_cnt < 2; i++) tick();
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (done_cnt !== 2 || x_sel.size() !== 5) begin
            errors++;
            $display("FAIL repeat got done%0d xfer%0d want 2 5",
                done_cnt, x_sel.size());
        end else begin
            checks++;
            if (x_sel[2] !== 3'b001 || x_sel[3] !== 3'b010
                || x_ch[4] !== 4'd6) begin
                errors++;
                $display("FAIL repeat_order got %b %b %h want 001 010 6",
                    x_sel[2], x_sel[3], x_ch[4]);
            end
        end
        checks++;
        if (bad_sel !== 0) begin
            errors++;
            $display("FAIL onehot got %0d want 0", bad_sel);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_stall();
        test_empty();
        test_reset_mid();
        test_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
